// File: rtl/lcd_pkg.sv
// Shared constants and types for the HD44780 command/data sequencer.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNCSET = 8'h38;
  localparam logic [7:0] LCD_DISPON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_ENTRY   = 8'h06;
  localparam logic [7:0] LCD_LINE1   = 8'h80;
  localparam logic [7:0] LCD_LINE2   = 8'hC0;

  localparam int INIT_STEPS = 7;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_ISSUE,
    ST_WAIT_FIN,
    ST_DELAY,
    ST_NEXT,
    ST_READY,
    ST_DONE
  } state_t;

  // Command byte for each power-up initialisation step.
  function automatic logic [7:0] init_cmd(input logic [2:0] step);
    logic [7:0] cmd;
    case (step)
      3'd0, 3'd1, 3'd2, 3'd3: cmd = LCD_FUNCSET;
      3'd4:                   cmd = LCD_DISPON;
      3'd5:                   cmd = LCD_CLEAR;
      default:                cmd = LCD_ENTRY;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/ms_delay.sv
// Loadable down-counter; done is high whenever the count has drained to zero.
module ms_delay #(
  parameter int W = 8
) (
  input  logic         clk_1ms,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_1ms or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/lcd_sequencer.sv
// HD44780 sequencer: power-up init in 8-bit 2-line mode, then full-screen
// rewrites from a latched 32-byte text vector, one write cycle at a time.
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int PWRUP_MS        = 20,
  parameter int FUNCSET_WAIT_MS = 5,
  parameter int CLR_WAIT_MS     = 2,
  parameter int TIMEOUT_CYC     = 8
) (
  input  logic         clk_1ms,
  input  logic         reset_n,
  input  logic         upd_req,
  input  logic [255:0] text_in,
  input  logic         wr_finish,
  output logic         wr_enable,
  output logic         reg_sel,
  output logic [7:0]   lcd_data,
  output logic         ready,
  output logic         upd_done,
  output logic         fault
);

  // One cycle is spent loading the counter and one in ISSUE, so the first
  // wr_enable lands exactly PWRUP_MS cycles after entering PWRUP.
  localparam logic [7:0] PWRUP_LOAD = 8'(PWRUP_MS - 3);
  localparam logic [7:0] FUNCSET_W  = 8'(FUNCSET_WAIT_MS);
  localparam logic [7:0] CLR_W      = 8'(CLR_WAIT_MS);
  localparam logic [7:0] TIMEOUT_W  = 8'(TIMEOUT_CYC);

  state_t         state_q, state_d;
  logic [2:0]     step_q, step_d;
  logic           upd_q, upd_d;
  logic           cmd_q, cmd_d;
  logic [4:0]     idx_q, idx_d;
  logic [255:0]   text_q, text_d;
  logic           arm_q, arm_d;
  logic           wr_enable_q, wr_enable_d;
  logic           reg_sel_q, reg_sel_d;
  logic [7:0]     lcd_data_q, lcd_data_d;
  logic           ready_q, ready_d;
  logic           upd_done_q, upd_done_d;
  logic           fault_q, fault_d;

  logic           dly_load, dly_done, wd_load, wd_done;
  logic [7:0]     dly_val, post_wait;
  logic [7:0]     text_bytes [32];

  for (genvar gi = 0; gi < 32; gi++) begin : g_bytes
    assign text_bytes[gi] = text_q[255 - 8*gi -: 8];
  end

  ms_delay #(.W(8)) u_delay (
    .clk_1ms (clk_1ms), .reset_n (reset_n),
    .load (dly_load), .load_val (dly_val), .done (dly_done)
  );

  ms_delay #(.W(8)) u_watchdog (
    .clk_1ms (clk_1ms), .reset_n (reset_n),
    .load (wd_load), .load_val (TIMEOUT_W), .done (wd_done)
  );

  always_comb begin
    post_wait = 8'd0;
    if (!upd_q) begin
      case (step_q)
        3'd0:    post_wait = FUNCSET_W;
        3'd1:    post_wait = 8'd1;
        3'd5:    post_wait = CLR_W;
        default: post_wait = 8'd0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    upd_d       = upd_q;
    cmd_d       = cmd_q;
    idx_d       = idx_q;
    text_d      = text_q;
    arm_d       = arm_q;
    reg_sel_d   = reg_sel_q;
    lcd_data_d  = lcd_data_q;
    fault_d     = fault_q;
    wr_enable_d = 1'b0;
    dly_load    = 1'b0;
    dly_val     = 8'd0;
    wd_load     = 1'b0;

    case (state_q)
      ST_PWRUP: begin
        if (!arm_q) begin
          dly_load = 1'b1;
          dly_val  = PWRUP_LOAD;
          arm_d    = 1'b1;
        end else if (dly_done) begin
          arm_d   = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wr_enable_d = 1'b1;
        wd_load     = 1'b1;
        state_d     = ST_WAIT_FIN;
        if (!upd_q) begin
          reg_sel_d  = 1'b0;
          lcd_data_d = init_cmd(step_q);
        end else if (cmd_q) begin
          reg_sel_d  = 1'b0;
          lcd_data_d = (idx_q == 5'd0) ? LCD_LINE1 : LCD_LINE2;
        end else begin
          reg_sel_d  = 1'b1;
          lcd_data_d = text_bytes[idx_q];
        end
      end
      ST_WAIT_FIN: begin
        if (wr_finish) begin
          if (post_wait != 8'd0) begin
            dly_load = 1'b1;
            dly_val  = post_wait - 8'd1;
            state_d  = ST_DELAY;
          end else begin
            state_d = ST_NEXT;
          end
        end else if (wd_done) begin
          fault_d = 1'b1;
          step_d  = 3'd0;
          upd_d   = 1'b0;
          state_d = ST_PWRUP;
        end
      end
      ST_DELAY: begin
        if (dly_done) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (!upd_q) begin
          if (step_q == 3'(INIT_STEPS - 1)) begin
            state_d = ST_READY;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = ST_ISSUE;
          end
        end else if (cmd_q) begin
          // The index only crosses into line 2 once the 0xC0 command is out.
          cmd_d   = 1'b0;
          idx_d   = (idx_q == 5'd15) ? 5'd16 : idx_q;
          state_d = ST_ISSUE;
        end else if (idx_q == 5'd31) begin
          state_d = ST_DONE;
        end else begin
          if (idx_q == 5'd15) cmd_d = 1'b1;
          else                idx_d = idx_q + 5'd1;
          state_d = ST_ISSUE;
        end
      end
      ST_READY: begin
        if (upd_req) begin
          text_d  = text_in;
          idx_d   = 5'd0;
          cmd_d   = 1'b1;
          upd_d   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: state_d = ST_READY;
      default: state_d = ST_PWRUP;
    endcase

    ready_d    = (state_d == ST_READY);
    upd_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_1ms or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_PWRUP;
      step_q      <= 3'd0;
      upd_q       <= 1'b0;
      cmd_q       <= 1'b0;
      idx_q       <= 5'd0;
      text_q      <= '0;
      arm_q       <= 1'b0;
      wr_enable_q <= 1'b0;
      reg_sel_q   <= 1'b0;
      lcd_data_q  <= 8'd0;
      ready_q     <= 1'b0;
      upd_done_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      upd_q       <= upd_d;
      cmd_q       <= cmd_d;
      idx_q       <= idx_d;
      text_q      <= text_d;
      arm_q       <= arm_d;
      wr_enable_q <= wr_enable_d;
      reg_sel_q   <= reg_sel_d;
      lcd_data_q  <= lcd_data_d;
      ready_q     <= ready_d;
      upd_done_q  <= upd_done_d;
      fault_q     <= fault_d;
    end
  end

  assign wr_enable = wr_enable_q;
  assign reg_sel   = reg_sel_q;
  assign lcd_data  = lcd_data_q;
  assign ready     = ready_q;
  assign upd_done  = upd_done_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Scoreboard bench for lcd_sequencer with a write-stage model answering
// wr_finish four cycles after each wr_enable.
module tb_lcd_sequencer;

  logic         clk_1ms = 1'b0;
  logic         reset_n = 1'b0;
  logic         upd_req = 1'b0;
  logic [255:0] text_in = '0;
  logic         wr_finish;
  logic         wr_enable, reg_sel, ready, upd_done, fault;
  logic [7:0]   lcd_data;
  logic         model_fin = 1'b0;
  logic         tb_fin = 1'b0;

  assign wr_finish = model_fin | tb_fin;

  always #5 clk_1ms = ~clk_1ms;

  lcd_sequencer dut (
    .clk_1ms   (clk_1ms),
    .reset_n   (reset_n),
    .upd_req   (upd_req),
    .text_in   (text_in),
    .wr_finish (wr_finish),
    .wr_enable (wr_enable),
    .reg_sel   (reg_sel),
    .lcd_data  (lcd_data),
    .ready     (ready),
    .upd_done  (upd_done),
    .fault     (fault)
  );

  int         chk_cnt = 0;
  int         pass_cnt = 0;
  int         cyc = 0;
  int         wr_cnt = 0;
  int         done_cnt = 0;
  int         withhold_at = -1;
  int         we_at [256];
  int         fin_at [256];
  logic [8:0] exp_q [$];
  logic [8:0] held = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor + write-stage model: one process so counters never race.
  initial begin : monitor
    int timer;
    timer = 0;
    forever begin
      @(posedge clk_1ms);
      #1;
      cyc++;
      model_fin = 1'b0;
      if (!reset_n) begin
        timer = 0;
      end else if (timer > 0) begin
        timer--;
        if (timer == 0) begin
          model_fin = 1'b1;
          fin_at[wr_cnt % 256] = cyc;
          check("hold_during_write", {23'd0, reg_sel, lcd_data}, {23'd0, held});
        end
      end
      if (upd_done) done_cnt++;
      if (wr_enable) begin
        wr_cnt++;
        we_at[wr_cnt % 256] = cyc;
        held = {reg_sel, lcd_data};
        $display("write %0d: cycle %0d rs=%0d data=0x%02h", wr_cnt, cyc, reg_sel, lcd_data);
        if (exp_q.size() == 0) check("write_expected", exp_q.size(), 1);
        else check("write_byte", {23'd0, reg_sel, lcd_data}, {23'd0, exp_q.pop_front()});
        if (wr_cnt != withhold_at) timer = 4;
      end
    end
  end

  initial begin : global_guard
    #300000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

  task automatic push_init();
    exp_q.push_back(9'h038); exp_q.push_back(9'h038); exp_q.push_back(9'h038);
    exp_q.push_back(9'h038); exp_q.push_back(9'h00C); exp_q.push_back(9'h001);
    exp_q.push_back(9'h006);
  endtask

  task automatic push_update(input logic [255:0] txt);
    exp_q.push_back(9'h080);
    for (int k = 0; k < 16; k++) exp_q.push_back({1'b1, txt[255 - 8*k -: 8]});
    exp_q.push_back(9'h0C0);
    for (int k = 16; k < 32; k++) exp_q.push_back({1'b1, txt[255 - 8*k -: 8]});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_1ms);
  endtask

  task automatic wait_writes(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (wr_cnt < n && k < budget) begin @(negedge clk_1ms); k++; end
    if (wr_cnt < n) check(name, wr_cnt, n);
  endtask

  task automatic wait_ready(input int budget);
    int k;
    k = 0;
    while (!ready && k < budget) begin @(negedge clk_1ms); k++; end
    check("ready_reached", ready, 1);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!upd_done && k < budget) begin @(negedge clk_1ms); k++; end
    check("upd_done_seen", upd_done, 1);
  endtask

  initial begin : stimulus
    logic [255:0] txt;
    int base, base_cyc, d0, t, k;

    // Reset state
    #2;
    check("reset_outputs", {wr_enable, reg_sel, ready, upd_done, fault, lcd_data}, 0);

    // Power-up initialisation
    @(negedge clk_1ms);
    reset_n = 1'b1;
    base_cyc = cyc;
    push_init();
    wait_writes(1, 40, "first_write_timeout");
    check("pwrup_latency", we_at[1] - base_cyc, 20);
    wait_writes(2, 40, "second_write_timeout");
    check("funcset_gap_ge5", (we_at[2] - fin_at[1]) >= 5, 1);
    wait_ready(200);
    check("init_write_count", wr_cnt, 7);
    check("init_queue_empty", exp_q.size(), 0);

    // Full rewrite; a request in the DONE cycle must be ignored
    txt = {"SEJF ZAMKNIETY  ", "PIN: ****       "};
    text_in = txt;
    push_update(txt);
    base = wr_cnt;
    d0 = done_cnt;
    upd_req = 1'b1;
    @(negedge clk_1ms);
    upd_req = 1'b0;
    check("ready_drops", ready, 0);
    wait_done(400);
    upd_req = 1'b1;
    @(negedge clk_1ms);
    upd_req = 1'b0;
    check("ready_after_done", ready, 1);
    tick(12);
    check("update_write_count", wr_cnt - base, 34);
    check("upd_done_once", done_cnt - d0, 1);
    check("update_queue_empty", exp_q.size(), 0);

    // Text latched at request; second request mid-update ignored
    txt = {"0123456789ABCDEF", "abcdefghijklmnop"};
    text_in = txt;
    push_update(txt);
    base = wr_cnt;
    upd_req = 1'b1;
    @(negedge clk_1ms);
    upd_req = 1'b0;
    wait_writes(base + 5, 100, "latch_writes_timeout");
    text_in = {32{8'h58}};
    upd_req = 1'b1;
    @(negedge clk_1ms);
    upd_req = 1'b0;
    wait_done(400);
    wait_ready(10);
    tick(12);
    check("latch_write_count", wr_cnt - base, 34);
    check("latch_queue_empty", exp_q.size(), 0);

    // Spurious wr_finish while READY
    base = wr_cnt;
    tb_fin = 1'b1;
    @(negedge clk_1ms);
    tb_fin = 1'b0;
    tick(10);
    check("spurious_fin_no_write", wr_cnt, base);
    check("spurious_fin_ready", ready, 1);
    check("spurious_fin_no_fault", fault, 0);

    // Withheld wr_finish on the third init write
    reset_n = 1'b0;
    exp_q.delete();
    tick(2);
    reset_n = 1'b1;
    base = wr_cnt;
    withhold_at = base + 3;
    exp_q.push_back(9'h038); exp_q.push_back(9'h038); exp_q.push_back(9'h038);
    push_init();
    wait_writes(base + 3, 100, "third_write_timeout");
    k = 0;
    while (!fault && k < 30) begin @(negedge clk_1ms); k++; end
    t = cyc;
    check("fault_set", fault, 1);
    // fault appears in the cycle after the 8th finish-less cycle
    check("timeout_latency", t - we_at[(base + 3) % 256], 9);
    wait_writes(base + 4, 40, "restart_write_timeout");
    check("restart_latency", we_at[(base + 4) % 256] - t, 20);
    withhold_at = -1;
    wait_ready(300);
    check("restart_write_count", wr_cnt - base, 10);
    check("restart_queue_empty", exp_q.size(), 0);
    check("fault_sticky", fault, 1);

    // Reset during the post-clear wait
    reset_n = 1'b0;
    exp_q.delete();
    tick(2);
    reset_n = 1'b1;
    base = wr_cnt;
    push_init();
    wait_writes(base + 6, 200, "clear_write_timeout");
    k = 0;
    while (cyc < we_at[(base + 6) % 256] + 5 && k < 20) begin @(negedge clk_1ms); k++; end
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_outputs", {wr_enable, reg_sel, ready, upd_done, fault, lcd_data}, 0);
    check("entry_not_issued", exp_q.size(), 1);
    exp_q.delete();
    tick(3);
    check("reset_held_quiet", {wr_enable, reg_sel, lcd_data}, 0);
    reset_n = 1'b1;
    base_cyc = cyc;
    base = wr_cnt;
    push_init();
    wait_writes(base + 1, 40, "reinit_write_timeout");
    check("reinit_latency", we_at[(base + 1) % 256] - base_cyc, 20);
    wait_ready(200);
    check("reinit_write_count", wr_cnt - base, 7);
    check("reinit_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
